icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache between the IF stage and the byte-wide RAM controller.
- Serves hits combinationally in the same cycle.
- On a miss, refills a whole line byte-serially through the RAM controller, and installs it with the address latched at miss time.
- Adds over the previous generation: configurable way count, invalid-first/round-robin replacement, a flush input, and a well-defined controller stall handshake.

Parameters:
- WAY_NUM, 2, number of ways per row; power of two, 1..8.
- INSTSEL_BIT, 2, log2 of 32-bit words per line; line is 4<<INSTSEL_BIT bytes.
- ROW_BIT, 2, log2 of number of rows (sets).
- ADDR_BIT, 17, significant address bits; TAG_BIT = ADDR_BIT-2-INSTSEL_BIT-ROW_BIT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- re_IF_i  in  1  fetch request
- addr_IF_i  in  32  fetch byte address; word-aligned
- data_IF_o  out  32  fetched instruction
- miss_IF_o  out  1  IF must hold address and retry
- flush_i  in  1  one-cycle pulse; invalidate all lines (fence.i)
- re_CTRL_o  out  1  RAM read request
- addr_CTRL_o  out  32  RAM byte address
- data_RAM_i  in  8  RAM byte; valid one cycle after an accepted address
- stl_CTRL_i  in  1  controller busy; request not accepted this cycle

Behaviour:
- Address split: inst = addr[INSTSEL_BIT+1:2]; row = next ROW_BIT bits; tag = next TAG_BIT bits. Bits at and above ADDR_BIT are ignored.
- Hit: re_IF_i=1 and some way of the row is valid with a matching tag. Tag matches in multiple ways cannot occur.
- miss_IF_o = re_IF_i & ~hit, combinational.
- data_IF_o = hit word when re_IF_i & hit, else 0.
- Reset (async, rst_n=0):
  - all valid bits and victim pointers cleared;
  - re_CTRL_o=0, addr_CTRL_o=0, FSM=IDLE;
  - a fill in progress is abandoned and nothing is installed.
- FSM IDLE:
  - Entered when miss_IF_o=1 and flush_i=0.
  - Latch row, tag and victim way. Victim is the lowest-index invalid way of the row, otherwise the row's round-robin pointer.
  - Next cycle: re_CTRL_o=1, addr_CTRL_o = line base (low INSTSEL_BIT+2 bits zero). Go to REQ.
- FSM REQ:
  - If stl_CTRL_i=1: hold address and re_CTRL_o; no byte captured.
  - If stl_CTRL_i=0: address accepted; increment addr_CTRL_o each cycle; go to FILL.
- FSM FILL:
  - stl_CTRL_i is ignored.
  - Each cycle capture data_RAM_i as line byte k into word k>>2, bits [8*(k%4)+:8] (little-endian). k counts 0..LINE_BYTES-1.
  - After the last address is issued, re_CTRL_o=0 and addr_CTRL_o=0.
  - After byte LINE_BYTES-1 is captured, go to DONE.
- FSM DONE (1 cycle):
  - Write tag, set valid (unless poisoned), set the row pointer to (victim+1) mod WAY_NUM, return to IDLE.
  - The following cycle hits if IF still presents the same line.
- Latency: accepted request to line-installed = LINE_BYTES+1 cycles. Cold miss without stall: IF sees data LINE_BYTES+3 cycles after the first miss cycle.
- re_IF_i dropping, or the address changing, mid-fill: the fill still completes for the latched line. A new miss is handled only in IDLE.
- flush_i:
  - Clears all valid bits next edge; victim pointers are untouched.
  - In REQ or FILL: the fill continues but is poisoned; DONE does not set valid.
  - flush_i in IDLE with a simultaneous miss: flush wins; the miss is taken next cycle.
- WAY_NUM=1: direct-mapped; the pointer is a constant 0.

Optional Feature:
- Macro: ICACHE_STAT_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments each cycle with re_IF_i & hit.
  - miss_cnt_o increments on each IDLE→REQ transition.
  - Both wrap at 2^32 and are not cleared by flush_i.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: RAM byte n = n[7:0]; re_IF_i=1, addr 0x00014 → next cycle re_CTRL_o=1 with addr_CTRL_o=0x00010 and addresses step to 0x0001F. miss_IF_o falls 19 cycles after the first miss cycle. data_IF_o=0x17161514.
- Two ways, same row: fill 0x00000 then 0x00040 → both then hit alternately with re_CTRL_o held 0.
- Replacement: after the fills above, access 0x00080 → evicts way 0. Then 0x00000 misses and 0x00040 hits.
- Stall: stl_CTRL_i=1 for 3 cycles at REQ → addr_CTRL_o held at 0x00010 and no capture. The line is installed 3 cycles later than the cold-miss case, and the data is identical.
- Flush mid-fill: pulse flush_i at FILL byte 5 → fill runs to completion, miss_IF_o stays 1, and a second full refill follows. Also flush_i with a simultaneous miss in IDLE → REQ entered one cycle later.
- Reset mid-fill: rst_n low at byte 8 → re_CTRL_o=0 immediately. After release, the same address misses and refills. With ICACHE_STAT_EN: 3 hits and 2 misses → hit_cnt_o=3, miss_cnt_o=2.

Source files
------------

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only I-cache with byte-serial refill.
// Define ICACHE_STAT_EN to add the hit_cnt_o / miss_cnt_o counters.
module icache_nway #(
  parameter int WAY_NUM     = 2,
  parameter int INSTSEL_BIT = 2,
  parameter int ROW_BIT     = 2,
  parameter int ADDR_BIT    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_IF_i,
  input  logic [31:0] addr_IF_i,
  output logic [31:0] data_IF_o,
  output logic        miss_IF_o,
  input  logic        flush_i,
  output logic        re_CTRL_o,
  output logic [31:0] addr_CTRL_o,
  input  logic [7:0]  data_RAM_i,
`ifdef ICACHE_STAT_EN
  input  logic        stl_CTRL_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`else
  input  logic        stl_CTRL_i
`endif
);

  localparam int TAG_BIT    = ADDR_BIT - 2 - INSTSEL_BIT - ROW_BIT;
  localparam int OFF_B      = INSTSEL_BIT + 2;
  localparam int LINE_BYTES = 4 << INSTSEL_BIT;
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int ROWS       = 1 << ROW_BIT;
  localparam int WAY_B      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int KB         = OFF_B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE
  } state_t;

  state_t r_state, w_nxt;

  logic [LINE_W-1:0]  r_data  [ROWS][WAY_NUM];
  logic [TAG_BIT-1:0] r_tag   [ROWS][WAY_NUM];
  logic [WAY_NUM-1:0] r_valid [ROWS];
  logic [WAY_B-1:0]   r_rr    [ROWS];

  logic [LINE_W-1:0]  r_line;
  logic [ROW_BIT-1:0] r_row;
  logic [TAG_BIT-1:0] r_tag_l;
  logic [WAY_B-1:0]   r_vict;
  logic [KB-1:0]      r_k;
  logic               r_re;
  logic               r_poison;
  logic [31:0]        r_addr;

  logic [INSTSEL_BIT-1:0] w_inst;
  logic [ROW_BIT-1:0]     w_row;
  logic [TAG_BIT-1:0]     w_tag;
  logic                   w_match;
  logic [WAY_B-1:0]       w_hit_way;
  logic                   w_inv;
  logic [WAY_B-1:0]       w_inv_way;
  logic                   w_hit;
  logic                   w_miss;
  logic [LINE_W-1:0]      w_line;
  logic [31:0]            w_base;
  logic [WAY_B-1:0]       w_vict_nxt;
  logic                   w_unused;

  assign w_inst = addr_IF_i[2 +: INSTSEL_BIT];
  assign w_row  = addr_IF_i[OFF_B +: ROW_BIT];
  assign w_tag  = addr_IF_i[OFF_B+ROW_BIT +: TAG_BIT];
  assign w_unused = ^{addr_IF_i[31:ADDR_BIT], addr_IF_i[1:0]};

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (r_valid[w_row][w] && (r_tag[w_row][w] == w_tag)) begin
        w_match   = 1'b1;
        w_hit_way = WAY_B'(w);
      end
      if (!r_valid[w_row][w]) begin
        w_inv     = 1'b1;
        w_inv_way = WAY_B'(w);
      end
    end
  end

  assign w_hit      = re_IF_i & w_match;
  assign w_miss     = re_IF_i & ~w_match;
  assign w_line     = r_data[w_row][w_hit_way];
  assign w_base     = 32'({w_tag, w_row}) << OFF_B;
  assign w_vict_nxt = (WAY_NUM == 1) ? '0 : r_vict + WAY_B'(1);

  assign miss_IF_o   = w_miss;
  assign data_IF_o   = w_hit ? w_line[{w_inst, 5'b0} +: 32] : 32'd0;
  assign re_CTRL_o   = r_re;
  assign addr_CTRL_o = r_addr;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_miss && !flush_i) w_nxt = S_REQ;
      S_REQ:   if (!stl_CTRL_i) w_nxt = S_FILL;
      S_FILL:  if (r_k == KB'(LINE_BYTES - 1)) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_re     <= 1'b0;
      r_addr   <= '0;
      r_k      <= '0;
      r_poison <= 1'b0;
      r_row    <= '0;
      r_tag_l  <= '0;
      r_vict   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_valid[r] <= '0;
        r_rr[r]    <= '0;
      end
    end else begin
      r_state <= w_nxt;
      if (flush_i) begin
        for (int r = 0; r < ROWS; r++) r_valid[r] <= '0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_nxt == S_REQ) begin
            r_row    <= w_row;
            r_tag_l  <= w_tag;
            r_vict   <= w_inv ? w_inv_way : r_rr[w_row];
            r_re     <= 1'b1;
            r_addr   <= w_base;
            r_k      <= '0;
            r_poison <= 1'b0;
          end
        end
        S_REQ: begin
          if (flush_i) r_poison <= 1'b1;
          if (!stl_CTRL_i) r_addr <= r_addr + 32'd1;
        end
        S_FILL: begin
          if (flush_i) r_poison <= 1'b1;
          r_k <= r_k + KB'(1);
          // Last address goes out while byte LINE_BYTES-2 is captured.
          if (r_k == KB'(LINE_BYTES - 2)) begin
            r_re   <= 1'b0;
            r_addr <= '0;
          end else if (r_re) begin
            r_addr <= r_addr + 32'd1;
          end
        end
        S_DONE: begin
          if (!r_poison && !flush_i) r_valid[r_row][r_vict] <= 1'b1;
          r_rr[r_row] <= w_vict_nxt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL) r_line[{r_k, 3'b000} +: 8] <= data_RAM_i;
    if (r_state == S_DONE) begin
      r_data[r_row][r_vict] <= r_line;
      r_tag[r_row][r_vict]  <= r_tag_l;
    end
  end

`ifdef ICACHE_STAT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == S_IDLE && w_nxt == S_REQ) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed bench for icache_nway with a byte-wide RAM model.
// RAM byte at address n is n[7:0], returned one cycle after acceptance.
module tb_icache_nway;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_IF_i = 1'b0;
  logic [31:0] addr_IF_i = '0;
  logic [31:0] data_IF_o;
  logic        miss_IF_o;
  logic        flush_i = 1'b0;
  logic        re_CTRL_o;
  logic [31:0] addr_CTRL_o;
  logic [7:0]  data_RAM_i = '0;
  logic        stl_CTRL_i = 1'b0;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re_CTRL_o && !stl_CTRL_i) data_RAM_i <= addr_CTRL_o[7:0];
  end

  icache_nway dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .re_IF_i     (re_IF_i),
    .addr_IF_i   (addr_IF_i),
    .data_IF_o   (data_IF_o),
    .miss_IF_o   (miss_IF_o),
    .flush_i     (flush_i),
    .re_CTRL_o   (re_CTRL_o),
    .addr_CTRL_o (addr_CTRL_o),
    .data_RAM_i  (data_RAM_i),
`ifdef ICACHE_STAT_EN
    .stl_CTRL_i  (stl_CTRL_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`else
    .stl_CTRL_i  (stl_CTRL_i)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    re_IF_i    = 1'b0;
    flush_i    = 1'b0;
    stl_CTRL_i = 1'b0;
    addr_IF_i  = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_hit(inout int c);
    int lim;
    lim = c + 60;
    while (miss_IF_o && c < lim) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (re_CTRL_o !== 1'b0 || addr_CTRL_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl re=%b addr=%h required 0 00000000",
               re_CTRL_o, addr_CTRL_o);
    end
    checks++;
    if (miss_IF_o !== 1'b0 || data_IF_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_if miss=%b data=%h required 0 00000000",
               miss_IF_o, data_IF_o);
    end
  endtask

  task automatic test_cold_miss();
    int c;
    logic        exp_re;
    logic [31:0] exp_a;
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h14;
    #1;
    checks++;
    if (miss_IF_o !== 1'b1 || re_CTRL_o !== 1'b0) begin
      errors++;
      $display("FAIL cold_first miss=%b re_ctrl=%b required 1 0",
               miss_IF_o, re_CTRL_o);
    end
    c = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      c++;
      exp_re = (i <= 16);
      exp_a  = (i <= 16) ? 32'(32'h10 + i - 1) : 32'd0;
      checks++;
      if (re_CTRL_o !== exp_re || addr_CTRL_o !== exp_a) begin
        errors++;
        $display("FAIL cold_addr cyc=%0d re=%b addr=%h required %b %h",
                 i, re_CTRL_o, addr_CTRL_o, exp_re, exp_a);
      end
    end
    wait_hit(c);
    checks++;
    if (c !== 19) begin
      errors++;
      $display("FAIL cold_latency got=%0d required 19", c);
    end
    checks++;
    if (data_IF_o !== 32'h17161514) begin
      errors++;
      $display("FAIL cold_data got=%h required 17161514", data_IF_o);
    end
    re_IF_i = 1'b0;
    tick();
  endtask

  task automatic test_two_ways();
    int c;
    logic [31:0] a_tab [8];
    logic [31:0] d_tab [8];
    a_tab = '{32'h00, 32'h40, 32'h04, 32'h44,
              32'h08, 32'h48, 32'h0C, 32'h4C};
    d_tab = '{32'h03020100, 32'h43424140, 32'h07060504, 32'h47464544,
              32'h0B0A0908, 32'h4B4A4948, 32'h0F0E0D0C, 32'h4F4E4D4C};
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h00;
    #1;
    c = 0;
    wait_hit(c);
    checks++;
    if (c !== 19) begin
      errors++;
      $display("FAIL fill0_latency got=%0d required 19", c);
    end
    addr_IF_i = 32'h40;
    #1;
    c = 0;
    wait_hit(c);
    checks++;
    if (c !== 19) begin
      errors++;
      $display("FAIL fill40_latency got=%0d required 19", c);
    end
    for (int i = 0; i < 8; i++) begin
      addr_IF_i = a_tab[i];
      #1;
      checks++;
      if (miss_IF_o !== 1'b0 || re_CTRL_o !== 1'b0 || data_IF_o !== d_tab[i]) begin
        errors++;
        $display("FAIL alt_hit addr=%h miss=%b re=%b data=%h required 0 0 %h",
                 a_tab[i], miss_IF_o, re_CTRL_o, data_IF_o, d_tab[i]);
      end
      tick();
    end
  endtask

  task automatic test_replacement();
    int c;
    addr_IF_i = 32'h80;
    #1;
    c = 0;
    wait_hit(c);
    checks++;
    if (c !== 19 || data_IF_o !== 32'h83828180) begin
      errors++;
      $display("FAIL repl_fill lat=%0d data=%h required 19 83828180",
               c, data_IF_o);
    end
    addr_IF_i = 32'h00;
    #1;
    checks++;
    if (miss_IF_o !== 1'b1) begin
      errors++;
      $display("FAIL repl_evicted miss=%b required 1", miss_IF_o);
    end
    addr_IF_i = 32'h40;
    #1;
    checks++;
    if (miss_IF_o !== 1'b0 || data_IF_o !== 32'h43424140) begin
      errors++;
      $display("FAIL repl_kept miss=%b data=%h required 0 43424140",
               miss_IF_o, data_IF_o);
    end
    tick();
    re_IF_i = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int c;
    do_reset();
    re_IF_i    = 1'b1;
    addr_IF_i  = 32'h14;
    stl_CTRL_i = 1'b1;
    #1;
    c = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      c++;
      if (i == 4) stl_CTRL_i = 1'b0;
      checks++;
      if (re_CTRL_o !== 1'b1 || addr_CTRL_o !== 32'h10) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d re=%b addr=%h required 1 00000010",
                 i, re_CTRL_o, addr_CTRL_o);
      end
    end
    tick();
    c++;
    checks++;
    if (addr_CTRL_o !== 32'h11) begin
      errors++;
      $display("FAIL stall_resume addr=%h required 00000011", addr_CTRL_o);
    end
    wait_hit(c);
    checks++;
    if (c !== 22 || data_IF_o !== 32'h17161514) begin
      errors++;
      $display("FAIL stall_done lat=%0d data=%h required 22 17161514",
               c, data_IF_o);
    end
    re_IF_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int c;
    do_reset();
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h14;
    #1;
    c = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      c++;
    end
    flush_i = 1'b1;
    tick();
    c++;
    flush_i = 1'b0;
    while (c < 19) begin
      tick();
      c++;
    end
    checks++;
    if (miss_IF_o !== 1'b1 || re_CTRL_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_poison miss=%b re=%b required 1 0",
               miss_IF_o, re_CTRL_o);
    end
    tick();
    c++;
    checks++;
    if (re_CTRL_o !== 1'b1 || addr_CTRL_o !== 32'h10) begin
      errors++;
      $display("FAIL flush_refill re=%b addr=%h required 1 00000010",
               re_CTRL_o, addr_CTRL_o);
    end
    wait_hit(c);
    checks++;
    if (c !== 38 || data_IF_o !== 32'h17161514) begin
      errors++;
      $display("FAIL flush_done lat=%0d data=%h required 38 17161514",
               c, data_IF_o);
    end
    addr_IF_i = 32'h24;
    flush_i   = 1'b1;
    #1;
    tick();
    flush_i = 1'b0;
    c = 1;
    checks++;
    if (re_CTRL_o !== 1'b0 || miss_IF_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_wins re=%b miss=%b required 0 1",
               re_CTRL_o, miss_IF_o);
    end
    tick();
    c++;
    checks++;
    if (re_CTRL_o !== 1'b1 || addr_CTRL_o !== 32'h20) begin
      errors++;
      $display("FAIL flush_idle_req re=%b addr=%h required 1 00000020",
               re_CTRL_o, addr_CTRL_o);
    end
    wait_hit(c);
    checks++;
    if (c !== 20 || data_IF_o !== 32'h27262524) begin
      errors++;
      $display("FAIL flush_idle_done lat=%0d data=%h required 20 27262524",
               c, data_IF_o);
    end
    addr_IF_i = 32'h14;
    #1;
    checks++;
    if (miss_IF_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_invalidated miss=%b required 1", miss_IF_o);
    end
    re_IF_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int c;
    do_reset();
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h14;
    #1;
    for (int i = 1; i <= 10; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (re_CTRL_o !== 1'b0 || addr_CTRL_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid re=%b addr=%h required 0 00000000",
               re_CTRL_o, addr_CTRL_o);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (miss_IF_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_miss miss=%b required 1", miss_IF_o);
    end
    c = 0;
    wait_hit(c);
    checks++;
    if (c !== 19 || data_IF_o !== 32'h17161514) begin
      errors++;
      $display("FAIL rst_mid_refill lat=%0d data=%h required 19 17161514",
               c, data_IF_o);
    end
    re_IF_i = 1'b0;
    tick();
  endtask

`ifdef ICACHE_STAT_EN
  task automatic test_stats();
    int c;
    do_reset();
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h14;
    #1;
    c = 0;
    wait_hit(c);
    re_IF_i = 1'b0;
    tick();
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h24;
    #1;
    c = 0;
    wait_hit(c);
    re_IF_i = 1'b0;
    tick();
    re_IF_i   = 1'b1;
    addr_IF_i = 32'h14;
    #1;
    for (int i = 0; i < 3; i++) tick();
    re_IF_i = 1'b0;
    #1;
    checks++;
    if (hit_cnt_o !== 32'd3 || miss_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL stats hit=%0d miss=%0d required 3 2",
               hit_cnt_o, miss_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_two_ways();
    test_replacement();
    test_stall();
    test_flush();
    test_reset_mid_fill();
`ifdef ICACHE_STAT_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
